pll_rst_seq: RTL and testbench



---
 rtl/pll_rst_pkg.sv | 19 +
 rtl/sync_2ff.sv | 27 ++
 rtl/pll_rst_seq.sv | 143 ++++++++++++++
 tb/tb_pll_rst_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_pkg.sv
// Shared types and 24 MHz-derived default timing for the PLL reset sequencer.
// Holds the sequencer state encoding and the default cycle counts.
package pll_rst_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int unsigned DEF_PLL_RST_CYCLES     = 24;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 2400;
  localparam int unsigned DEF_LOCK_TIMEOUT       = 240000;
  localparam int unsigned DEF_SYS_HOLD_CYCLES    = 16;
  localparam int unsigned DEF_LOSS_FILTER        = 4;
  localparam int unsigned DEF_CNT_W              = 18;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, async active-high reset to 0.
// Ports: clk, rst, d_i[W] (async source), q_o[W] (synchronized).
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses PLL reset, qualifies lock, then releases core reset.
// Ports: clk, reset, pll_lock(async), soft_rst_req -> pll_rst, sys_rst, locked, state_o, relock_cnt.
module pll_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
  parameter int unsigned SYS_HOLD_CYCLES    = DEF_SYS_HOLD_CYCLES,
  parameter int unsigned LOSS_FILTER        = DEF_LOSS_FILTER,
  parameter int unsigned CNT_W              = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       soft_rst_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       locked,
  output logic [1:0] state_o,
  output logic [7:0] relock_cnt
);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SYS_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_FILTER - 1);

  logic lock_s;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk (clk),
    .rst (reset),
    .d_i (pll_lock),
    .q_o (lock_s)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stab_q, stab_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic [7:0]       rc_q, rc_d;
  logic             pll_rst_q, sys_rst_q, locked_q;
  logic             loss_act, loss_hit, relock;

  assign loss_act = (state_q == HOLD) || (state_q == RUN);
  assign loss_hit = loss_act && !lock_s && (loss_q == LOSS_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stab_d  = stab_q;
    tmo_d   = tmo_q;
    rc_d    = rc_q;
    relock  = 1'b0;
    loss_d  = '0;
    if (loss_act && !lock_s) loss_d = loss_q + 1'b1;

    unique case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          stab_d  = '0;
          tmo_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        tmo_d  = tmo_q + 1'b1;
        stab_d = lock_s ? stab_q + 1'b1 : '0;
        // Stability is checked first so it wins a tie with timeout.
        if (lock_s && stab_q == STAB_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          relock = 1'b1;
        end
      end
      HOLD: begin
        if (loss_hit) begin
          relock = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (loss_hit) begin
          relock = 1'b1;
        end else if (soft_rst_req) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
    endcase

    if (relock) begin
      state_d = PLL_RST;
      cnt_d   = '0;
      stab_d  = '0;
      tmo_d   = '0;
      loss_d  = '0;
      if (rc_q != 8'hFF) rc_d = rc_q + 1'b1;
    end
  end

  // Outputs decode the next state so they switch on the same edge as state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= PLL_RST;
      cnt_q     <= '0;
      stab_q    <= '0;
      tmo_q     <= '0;
      loss_q    <= '0;
      rc_q      <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stab_q    <= stab_d;
      tmo_q     <= tmo_d;
      loss_q    <= loss_d;
      rc_q      <= rc_d;
      pll_rst_q <= (state_d == PLL_RST);
      sys_rst_q <= (state_d != RUN);
      locked_q  <= (state_d == RUN);
    end
  end

  assign pll_rst    = pll_rst_q;
  assign sys_rst    = sys_rst_q;
  assign locked     = locked_q;
  assign state_o    = state_q;
  assign relock_cnt = rc_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Self-checking bench for pll_rst_seq with shortened timing.
// Expected outputs are queued per cycle and compared after each edge.
module tb_pll_rst_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       soft_rst_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       locked;
  logic [1:0] state_o;
  logic [7:0] relock_cnt;

  int checks = 0;
  int errors = 0;

  logic [12:0] exp_q[$];
  logic [12:0] e;
  wire  [12:0] obs = {pll_rst, sys_rst, locked, state_o, relock_cnt};

  pll_rst_seq #(
    .PLL_RST_CYCLES     (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT       (32),
    .SYS_HOLD_CYCLES    (3),
    .LOSS_FILTER        (2),
    .CNT_W              (18)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pll_lock     (pll_lock),
    .soft_rst_req (soft_rst_req),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .locked       (locked),
    .state_o      (state_o),
    .relock_cnt   (relock_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [12:0] exp_of(int st, int rc);
    logic [1:0] s2;
    s2 = st[1:0];
    return {st == 0, st != 3, st == 3, s2, rc[7:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    pll_lock = 1'b0;
    soft_rst_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic bring_up;
    do_reset();
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (k == 6) pll_lock = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    pll_lock = 1'b0;
    soft_rst_req = 1'b0;
    tick();
    tick();
    exp_q.push_back(exp_of(0, 0));
    checks++;
    e = exp_q.pop_front();
    if (obs !== e) begin
      errors++;
      $display("FAIL reset got %h exp %h", obs, e);
    end
    reset = 1'b0;
  endtask

  task automatic test_powerup;
    int st;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      st = (k < 4) ? 0 : (k < 16) ? 1 : (k < 19) ? 2 : 3;
      exp_q.push_back(exp_of(st, 0));
      tick();
      checks++;
      e = exp_q.pop_front();
      if (obs !== e) begin
        errors++;
        $display("FAIL powerup k=%0d got %h exp %h", k, obs, e);
      end
      if (k == 6) pll_lock = 1'b1;
    end
  endtask

  task automatic test_glitch;
    int st;
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      st = (k < 4) ? 0 : (k < 20) ? 1 : (k < 23) ? 2 : 3;
      exp_q.push_back(exp_of(st, 0));
      tick();
      checks++;
      e = exp_q.pop_front();
      if (obs !== e) begin
        errors++;
        $display("FAIL glitch k=%0d got %h exp %h", k, obs, e);
      end
      if (k == 4) pll_lock = 1'b1;
      if (k == 9) pll_lock = 1'b0;
      if (k == 10) pll_lock = 1'b1;
    end
  endtask

  task automatic test_timeout;
    int st;
    int rc;
    do_reset();
    for (int k = 1; k <= 41; k++) begin
      st = (k < 4) ? 0 : (k < 36) ? 1 : (k < 40) ? 0 : 1;
      rc = (k >= 36) ? 1 : 0;
      exp_q.push_back(exp_of(st, rc));
      tick();
      checks++;
      e = exp_q.pop_front();
      if (obs !== e) begin
        errors++;
        $display("FAIL timeout k=%0d got %h exp %h", k, obs, e);
      end
    end
    for (int k = 42; k <= 36 * 300 + 4; k++) begin
      if (k == 36 * 255 - 1) exp_q.push_back(exp_of(1, 254));
      if (k == 36 * 255)     exp_q.push_back(exp_of(0, 255));
      if (k == 36 * 300)     exp_q.push_back(exp_of(0, 255));
      if (k == 36 * 300 + 4) exp_q.push_back(exp_of(1, 255));
      tick();
      if (exp_q.size() != 0) begin
        checks++;
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++;
          $display("FAIL saturate k=%0d got %h exp %h", k, obs, e);
        end
      end
    end
  endtask

  task automatic test_run_glitch;
    bring_up();
    pll_lock = 1'b0;
    for (int r = 1; r <= 6; r++) begin
      exp_q.push_back(exp_of(3, 0));
      tick();
      if (r == 1) pll_lock = 1'b1;
      checks++;
      e = exp_q.pop_front();
      if (obs !== e) begin
        errors++;
        $display("FAIL run_glitch r=%0d got %h exp %h", r, obs, e);
      end
    end
  endtask

  task automatic test_run_loss;
    bring_up();
    pll_lock = 1'b0;
    for (int r = 1; r <= 6; r++) begin
      exp_q.push_back((r < 4) ? exp_of(3, 0) : exp_of(0, 1));
      tick();
      checks++;
      e = exp_q.pop_front();
      if (obs !== e) begin
        errors++;
        $display("FAIL run_loss r=%0d got %h exp %h", r, obs, e);
      end
    end
  endtask

  task automatic test_soft;
    bring_up();
    soft_rst_req = 1'b1;
    for (int r = 1; r <= 6; r++) begin
      exp_q.push_back((r < 4) ? exp_of(2, 0) : exp_of(3, 0));
      tick();
      if (r == 1) soft_rst_req = 1'b0;
      checks++;
      e = exp_q.pop_front();
      if (obs !== e) begin
        errors++;
        $display("FAIL soft r=%0d got %h exp %h", r, obs, e);
      end
    end
  endtask

  task automatic test_soft_wait;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back((k < 4) ? exp_of(0, 0) : exp_of(1, 0));
      tick();
      checks++;
      e = exp_q.pop_front();
      if (obs !== e) begin
        errors++;
        $display("FAIL soft_wait k=%0d got %h exp %h", k, obs, e);
      end
      if (k == 5) soft_rst_req = 1'b1;
      if (k == 6) soft_rst_req = 1'b0;
    end
  endtask

  task automatic test_soft_loss;
    bring_up();
    pll_lock = 1'b0;
    for (int r = 1; r <= 5; r++) begin
      exp_q.push_back((r < 4) ? exp_of(3, 0) : exp_of(0, 1));
      tick();
      checks++;
      e = exp_q.pop_front();
      if (obs !== e) begin
        errors++;
        $display("FAIL soft_loss r=%0d got %h exp %h", r, obs, e);
      end
      if (r == 3) soft_rst_req = 1'b1;
      if (r == 4) soft_rst_req = 1'b0;
    end
  endtask

  task automatic test_reset_hold;
    do_reset();
    for (int k = 1; k <= 48; k++) begin
      if (k == 36) exp_q.push_back(exp_of(0, 1));
      if (k == 48) exp_q.push_back(exp_of(2, 1));
      tick();
      if (exp_q.size() != 0) begin
        checks++;
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++;
          $display("FAIL reset_hold_pre k=%0d got %h exp %h", k, obs, e);
        end
      end
      if (k == 36) pll_lock = 1'b1;
    end
    #2;
    reset = 1'b1;
    exp_q.push_back(exp_of(0, 0));
    #1;
    checks++;
    e = exp_q.pop_front();
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_hold_async got %h exp %h", obs, e);
    end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    pll_lock = 1'b0;
    soft_rst_req = 1'b0;
    test_reset();
    test_powerup();
    test_glitch();
    test_timeout();
    test_run_glitch();
    test_run_loss();
    test_soft();
    test_soft_wait();
    test_soft_loss();
    test_reset_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
